// File: rtl/sram_like_arbiter_if.sv
// sram-like request/response bundle shared by the arbiter ports.
// master: the side that issues requests; slave: the side that accepts them.
interface sram_like_arbiter_if;
    logic        req;
    logic        wr;
    logic [1:0]  size;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        addr_ok;
    logic        data_ok;
    logic [31:0] rdata;

    modport master (output req, wr, size, addr, wdata,
                    input  addr_ok, data_ok, rdata);
    modport slave  (input  req, wr, size, addr, wdata,
                    output addr_ok, data_ok, rdata);
endinterface

// File: rtl/sram_like_arbiter.sv
// 2:1 arbiter sharing one sram-like master port between the inst and data
// requesters. One outstanding transaction at a time. The grant is locked
// from the first issue cycle until the address handshake completes.
// Optional feature: define ROUND_ROBIN_EN to replace fixed DATA_PRIO priority
// with alternating priority tracked by rr_last.
module sram_like_arbiter #(
    parameter bit DATA_PRIO = 1'b1
) (
    input  logic                        clk,
    input  logic                        rst,
    sram_like_arbiter_if.slave          inst_if,
    sram_like_arbiter_if.slave          data_if,
    sram_like_arbiter_if.master         m_if
);
    typedef enum logic [1:0] {IDLE = 2'd0, ISSUE = 2'd1, WAIT = 2'd2} state_t;
    localparam logic SRC_INST = 1'b0;
    localparam logic SRC_DATA = 1'b1;

    state_t state_q, state_d;
    logic   owner_q, owner_d;
    logic   sel;        // arbitration winner in IDLE
    logic   src;        // source currently driving the master port
    logic   any_req;
    logic   addr_ok_src;
    logic   data_ok_src;

`ifdef ROUND_ROBIN_EN
    logic   rr_last_q, rr_last_d;
`endif

    assign any_req = inst_if.req | data_if.req;

    // Pick the winner among current requests.
    always_comb begin
        sel = SRC_INST;
        if (inst_if.req && data_if.req) begin
`ifdef ROUND_ROBIN_EN
            sel = ~rr_last_q;
`else
            sel = DATA_PRIO ? SRC_DATA : SRC_INST;
`endif
        end else if (data_if.req) begin
            sel = SRC_DATA;
        end
    end

    // In IDLE the winner drives the bus; afterwards the locked owner does.
    assign src = (state_q == IDLE) ? sel : owner_q;

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            owner_q <= SRC_INST;
`ifdef ROUND_ROBIN_EN
            rr_last_q <= SRC_INST;
`endif
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
`ifdef ROUND_ROBIN_EN
            rr_last_q <= rr_last_d;
`endif
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        owner_d = owner_q;
`ifdef ROUND_ROBIN_EN
        rr_last_d = rr_last_q;
        if (addr_ok_src) rr_last_d = src;
`endif
        case (state_q)
            IDLE: begin
                if (any_req) begin
                    owner_d = sel;
                    if (m_if.addr_ok) state_d = m_if.data_ok ? IDLE : WAIT;
                    else              state_d = ISSUE;
                end
            end
            ISSUE: begin
                if (m_if.addr_ok) state_d = m_if.data_ok ? IDLE : WAIT;
            end
            WAIT: begin
                if (m_if.data_ok) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Output logic: master request/fields and handshake routing to the owner.
    // m_data_ok outside an owned transaction (stray) is simply not routed.
    always_comb begin
        m_if.req    = 1'b0;
        addr_ok_src = 1'b0;
        data_ok_src = 1'b0;
        case (state_q)
            IDLE: begin
                m_if.req    = any_req;
                addr_ok_src = any_req & m_if.addr_ok;
                data_ok_src = any_req & m_if.addr_ok & m_if.data_ok;
            end
            ISSUE: begin
                m_if.req    = 1'b1;
                addr_ok_src = m_if.addr_ok;
                data_ok_src = m_if.addr_ok & m_if.data_ok;
            end
            WAIT: begin
                data_ok_src = m_if.data_ok;
            end
            default: ;
        endcase

        m_if.wr    = (src == SRC_DATA) ? data_if.wr    : inst_if.wr;
        m_if.size  = (src == SRC_DATA) ? data_if.size  : inst_if.size;
        m_if.addr  = (src == SRC_DATA) ? data_if.addr  : inst_if.addr;
        m_if.wdata = (src == SRC_DATA) ? data_if.wdata : inst_if.wdata;

        inst_if.addr_ok = addr_ok_src & (src == SRC_INST);
        data_if.addr_ok = addr_ok_src & (src == SRC_DATA);
        inst_if.data_ok = data_ok_src & (src == SRC_INST);
        data_if.data_ok = data_ok_src & (src == SRC_DATA);
    end

    assign inst_if.rdata = m_if.rdata;
    assign data_if.rdata = m_if.rdata;
endmodule

// File: tb/tb_sram_like_arbiter.sv
// Directed bench for sram_like_arbiter. Inputs change on the falling edge;
// outputs are sampled 1 ns later, well away from the rising edge.
module tb_sram_like_arbiter;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   vectors = 0;
    int   errs    = 0;

    sram_like_arbiter_if inst_bus ();
    sram_like_arbiter_if data_bus ();
    sram_like_arbiter_if m_bus ();

    sram_like_arbiter #(.DATA_PRIO(1'b1)) dut (
        .clk     (clk),
        .rst     (rst),
        .inst_if (inst_bus),
        .data_if (data_bus),
        .m_if    (m_bus)
    );

    always #5 clk = ~clk;

    task automatic chk1(input string tag, input logic obs, input logic exp);
        vectors++;
        assert (obs === exp) else begin
            errs++;
            $error("FAIL %s: got %b want %b", tag, obs, exp);
        end
    endtask

    task automatic chk32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            errs++;
            $error("FAIL %s: got %h want %h", tag, obs, exp);
        end
    endtask

    // Advance to the next falling edge (inputs are then changed by caller).
    task automatic step();
        @(negedge clk);
    endtask

    task automatic no_acks(input string tag);
        chk1({tag, " inst_addr_ok"}, inst_bus.addr_ok, 1'b0);
        chk1({tag, " data_addr_ok"}, data_bus.addr_ok, 1'b0);
        chk1({tag, " inst_data_ok"}, inst_bus.data_ok, 1'b0);
        chk1({tag, " data_data_ok"}, data_bus.data_ok, 1'b0);
    endtask

    initial begin
        inst_bus.req = 0; inst_bus.wr = 0; inst_bus.size = 2'd2;
        inst_bus.addr = 0; inst_bus.wdata = 0;
        data_bus.req = 0; data_bus.wr = 0; data_bus.size = 2'd2;
        data_bus.addr = 0; data_bus.wdata = 0;
        m_bus.addr_ok = 0; m_bus.data_ok = 0; m_bus.rdata = 0;

        // Reset
        step(); step();
        rst = 0; #1;
        chk1("rst m_req", m_bus.req, 1'b0);
        no_acks("rst");

        // 1: inst read, immediate addr_ok, data returns two cycles later
        step();
        inst_bus.req = 1; inst_bus.addr = 32'hBFC00000; m_bus.addr_ok = 1; #1;
        chk1("t1 m_req", m_bus.req, 1'b1);
        chk32("t1 m_addr", m_bus.addr, 32'hBFC00000);
        chk1("t1 inst_addr_ok", inst_bus.addr_ok, 1'b1);
        chk1("t1 data_addr_ok", data_bus.addr_ok, 1'b0);
        step();
        inst_bus.req = 0; m_bus.addr_ok = 0; #1;
        chk1("t1 wait m_req", m_bus.req, 1'b0);
        step();
        m_bus.data_ok = 1; m_bus.rdata = 32'h3C1D8000; #1;
        chk1("t1 inst_data_ok", inst_bus.data_ok, 1'b1);
        chk32("t1 inst_rdata", inst_bus.rdata, 32'h3C1D8000);
        chk1("t1 data_data_ok", data_bus.data_ok, 1'b0);
        step();
        m_bus.data_ok = 0;

        // 2: simultaneous requests, data side wins
        inst_bus.req = 1; inst_bus.addr = 32'hBFC00004;
        data_bus.req = 1; data_bus.wr = 1; data_bus.addr = 32'h80001000;
        data_bus.wdata = 32'h12345678; #1;
        chk1("t2 m_req", m_bus.req, 1'b1);
        chk32("t2 m_addr", m_bus.addr, 32'h80001000);
        chk1("t2 m_wr", m_bus.wr, 1'b1);
        chk32("t2 m_wdata", m_bus.wdata, 32'h12345678);
        step();
        m_bus.addr_ok = 1; #1;
        chk1("t2 data_addr_ok", data_bus.addr_ok, 1'b1);
        chk1("t2 inst_addr_ok", inst_bus.addr_ok, 1'b0);
        step();
        data_bus.req = 0; data_bus.wr = 0; m_bus.addr_ok = 0; #1;
        chk1("t2 wait m_req", m_bus.req, 1'b0);
        step();
        m_bus.data_ok = 1; #1;
        chk1("t2 data_data_ok", data_bus.data_ok, 1'b1);
        chk1("t2 inst_data_ok", inst_bus.data_ok, 1'b0);
        chk1("t2 bubble m_req", m_bus.req, 1'b0);
        step();
        m_bus.data_ok = 0; m_bus.addr_ok = 1; #1;
        chk32("t2 inst m_addr", m_bus.addr, 32'hBFC00004);
        chk1("t2 inst m_wr", m_bus.wr, 1'b0);
        chk1("t2 inst_addr_ok", inst_bus.addr_ok, 1'b1);
        step();
        inst_bus.req = 0; m_bus.addr_ok = 0; m_bus.data_ok = 1;
        m_bus.rdata = 32'h11112222; #1;
        chk1("t2 inst_data_ok", inst_bus.data_ok, 1'b1);
        chk32("t2 inst_rdata", inst_bus.rdata, 32'h11112222);
        step();
        m_bus.data_ok = 0;

        // 3: grant locked to inst while addr_ok is held off
        inst_bus.req = 1; inst_bus.addr = 32'hBFC00100; #1;
        chk32("t3 c1 m_addr", m_bus.addr, 32'hBFC00100);
        step();
        data_bus.req = 1; data_bus.addr = 32'h80002000; #1;
        chk32("t3 c2 m_addr", m_bus.addr, 32'hBFC00100);
        chk1("t3 c2 m_req", m_bus.req, 1'b1);
        chk1("t3 c2 data_addr_ok", data_bus.addr_ok, 1'b0);
        step(); #1;
        chk32("t3 c3 m_addr", m_bus.addr, 32'hBFC00100);
        step();
        m_bus.addr_ok = 1; #1;
        chk1("t3 inst_addr_ok", inst_bus.addr_ok, 1'b1);
        chk1("t3 data_addr_ok", data_bus.addr_ok, 1'b0);
        step();
        inst_bus.req = 0; m_bus.addr_ok = 0; m_bus.data_ok = 1; #1;
        chk1("t3 inst_data_ok", inst_bus.data_ok, 1'b1);
        chk1("t3 wait data_addr_ok", data_bus.addr_ok, 1'b0);
        chk1("t3 data_data_ok", data_bus.data_ok, 1'b0);
        step();
        m_bus.data_ok = 0; m_bus.addr_ok = 1; #1;
        chk1("t3 data_addr_ok late", data_bus.addr_ok, 1'b1);
        chk32("t3 data m_addr", m_bus.addr, 32'h80002000);
        step();
        data_bus.req = 0; m_bus.addr_ok = 0; m_bus.data_ok = 1; #1;
        chk1("t3 data_data_ok", data_bus.data_ok, 1'b1);
        step();
        m_bus.data_ok = 0;

        // 4: addr_ok and data_ok together in IDLE
        data_bus.req = 1; data_bus.addr = 32'h80003000;
        m_bus.addr_ok = 1; m_bus.data_ok = 1; m_bus.rdata = 32'hDEADBEEF; #1;
        chk1("t4 data_addr_ok", data_bus.addr_ok, 1'b1);
        chk1("t4 data_data_ok", data_bus.data_ok, 1'b1);
        chk32("t4 data_rdata", data_bus.rdata, 32'hDEADBEEF);
        chk1("t4 inst_data_ok", inst_bus.data_ok, 1'b0);
        step();
        // Still IDLE: a lone data_ok is stray and dropped
        data_bus.req = 0; m_bus.addr_ok = 0; m_bus.data_ok = 1; #1;
        no_acks("t4 stray");
        chk1("t4 stray m_req", m_bus.req, 1'b0);
        step();
        m_bus.data_ok = 0;

        // 5: reset while waiting for data
        inst_bus.req = 1; inst_bus.addr = 32'hBFC00200; m_bus.addr_ok = 1; #1;
        chk1("t5 inst_addr_ok", inst_bus.addr_ok, 1'b1);
        step();
        inst_bus.req = 0; m_bus.addr_ok = 0; rst = 1;
        step();
        rst = 0; m_bus.data_ok = 1; #1;
        no_acks("t5 post-rst");
        chk1("t5 m_req", m_bus.req, 1'b0);
        step();
        m_bus.data_ok = 0;

        // 6: both held for 4 transactions
        inst_bus.req = 1; data_bus.req = 1;
        inst_bus.addr = 32'hBFC00300; data_bus.addr = 32'h80004000;
        for (int i = 0; i < 4; i++) begin
            m_bus.addr_ok = 1; m_bus.data_ok = 0; #1;
`ifdef ROUND_ROBIN_EN
            chk1($sformatf("t6 grant%0d data", i), data_bus.addr_ok, (i % 2) == 0);
            chk1($sformatf("t6 grant%0d inst", i), inst_bus.addr_ok, (i % 2) == 1);
`else
            chk1($sformatf("t6 grant%0d data", i), data_bus.addr_ok, 1'b1);
            chk1($sformatf("t6 grant%0d inst", i), inst_bus.addr_ok, 1'b0);
`endif
            step();
            m_bus.addr_ok = 0; m_bus.data_ok = 1;
            step();
        end
        inst_bus.req = 0; data_bus.req = 0; m_bus.data_ok = 0; #1;
        chk1("end m_req", m_bus.req, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
        $finish;
    end
endmodule

// File: doc/sram_like_arbiter.md
Name: sram_like_arbiter

Overview:
Two-to-one arbiter sharing one sram-like master port (toward the AXI bridge) between the instruction-side and data-side sram-like requesters. It allows one outstanding transaction at a time. Data side has fixed priority by default, and a grant is locked from first issue until the address handshake completes. Read data and data_ok are routed back only to the requester that owns the transaction.

Parameters:
DATA_PRIO, 1, 1 = data side wins simultaneous requests, 0 = inst side wins (ignored when ROUND_ROBIN_EN is defined)

Ports:
clk  in  1  clock; all state on rising edge
rst  in  1  synchronous active-high reset
inst_req  in  1  inst request; held until inst_addr_ok
inst_wr  in  1  write flag (normally 0)
inst_size  in  2  transfer size
inst_addr  in  32  address
inst_wdata  in  32  write data
inst_addr_ok  out  1  address accepted for inst
inst_data_ok  out  1  inst transaction complete
inst_rdata  out  32  inst read data
data_req  in  1  data request; held until data_addr_ok
data_wr  in  1  1 = write
data_size  in  2  transfer size
data_addr  in  32  address
data_wdata  in  32  write data
data_addr_ok  out  1  address accepted for data
data_data_ok  out  1  data transaction complete
data_rdata  out  32  data read data
m_req  out  1  master request
m_wr  out  1  master write flag
m_size  out  2  master size
m_addr  out  32  master address
m_wdata  out  32  master write data
m_addr_ok  in  1  master address handshake
m_data_ok  in  1  master data return / write ack
m_rdata  in  32  master read data

Behaviour:
- State: state{IDLE,ISSUE,WAIT} and owner{INST,DATA}. Reset gives state=IDLE, owner=INST, and rr_last=INST when ROUND_ROBIN_EN is defined.
- With no requests, m_req and all *_addr_ok and *_data_ok are 0. m_wr/m_size/m_addr/m_wdata mirror the selected source. The rdata outputs mirror m_rdata and are valid only while the matching *_data_ok is high.
- IDLE:
  - sel = winner of inst_req/data_req per priority rule. m_req = inst_req|data_req, and master fields come from sel (combinational, zero-cycle issue).
  - m_addr_ok=1 gives sel_addr_ok=1 in the same cycle, owner<=sel, and state<=WAIT.
  - m_addr_ok=1 together with m_data_ok=1 also raises sel_data_ok the same cycle, and state stays IDLE.
  - A request with m_addr_ok=0 gives owner<=sel and state<=ISSUE, locking the grant.
- ISSUE:
  - m_req=1 with the owner's fields, whatever the other requester does.
  - On m_addr_ok, owner_addr_ok=1 and state<=WAIT. If m_data_ok is also high in that cycle, owner_data_ok=1 and state<=IDLE.
- WAIT:
  - m_req=0 and neither addr_ok is asserted.
  - On m_data_ok, owner_data_ok=1 and state<=IDLE. The next issue happens no earlier than the following cycle, so there is a 1-cycle bubble.
- m_data_ok in IDLE with no simultaneous m_addr_ok is stray. It is dropped and both *_data_ok stay 0.
- addr_ok and data_ok are never forwarded to the non-owner (or non-sel in IDLE).
- Reset mid-transaction (ISSUE/WAIT) returns to IDLE the next cycle. Any later m_data_ok for the abandoned transaction is dropped per the stray rule.
- A requester dropping req in ISSUE is a protocol violation. The arbiter keeps the grant until m_addr_ok.
- Fixed priority: the loser waits for one full transaction plus the bubble. It is granted in the next IDLE cycle if the winner is not requesting.

Optional Feature:
ROUND_ROBIN_EN:
- Defined: DATA_PRIO is ignored. On simultaneous requests in IDLE, the source not equal to rr_last wins. rr_last<=owner on each completed address handshake.
- Undefined: fixed priority per DATA_PRIO, and no rr_last register exists.

Test Plan:
1. Reset, then inst_req=1, addr 0xBFC00000, m_addr_ok=1 immediately, m_data_ok=1 two cycles later with rdata 0x3C1D8000 -> inst_addr_ok same cycle as m_req; inst_data_ok=1 with inst_rdata=0x3C1D8000; data_data_ok stays 0.
2. inst_req and data_req both 1 in the same cycle (data write 0x12345678 to 0x80001000), DATA_PRIO=1 -> m_addr=0x80001000, m_wr=1 first. inst is issued only after data_data_ok plus a 1-cycle bubble.
3. inst_req=1 with m_addr_ok low for 3 cycles, data_req rising in cycle 2 -> m_addr stays the inst address through ISSUE; data_addr_ok stays 0 until the inst transaction finishes.
4. m_addr_ok and m_data_ok both 1 in the same IDLE cycle for data read 0xDEADBEEF -> data_addr_ok and data_data_ok both 1 that cycle; state remains IDLE.
5. rst pulsed while in WAIT, then m_data_ok=1 -> no *_data_ok is asserted and m_req=0.
6. ROUND_ROBIN_EN defined, both requesters held continuously for 4 transactions -> grants alternate DATA, INST, DATA, INST (rr_last resets to INST).
